// File: rtl/regbank_wport_arb_pkg.sv
// Shared sizes and requester ids for the register-bank write-port arbiter.
package regbank_pkg;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int NREGS   = 17;
    localparam int SP_IDX  = 16;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_SP  = 2;
endpackage

// File: rtl/regbank_wport_arb_rr_arbiter.sv
// Round-robin one-hot arbiter: the first set req at or after ptr (wrapping) wins when en is high.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   winner,
    output logic            any
);
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        // Offset k walks priority order starting at ptr; position i matches exactly one k
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (en && !any && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    winner   = PW'(i);
                    any      = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regbank_wport_arb.sv
// Arbitrates NREQ writers onto the single bank write port with a registered issue stage.
// Define REGW_BYPASS_EN to forward the in-flight write onto rData1/rData2.
module regbank_wport_arb #(
    parameter int NREQ  = 3,
    parameter int AW    = regbank_pkg::AW,
    parameter int DW    = regbank_pkg::DW,
    parameter int NREGS = regbank_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              RegW,
    output logic [AW-1:0]     Rd,
    output logic [DW-1:0]     wrData,
    output logic [1:0]        grant_id,
    output logic              err_addr,
    output logic [7:0]        drop_cnt,
    input  logic [AW-1:0]     Rs,
    input  logic [AW-1:0]     Rt,
    input  logic [DW-1:0]     rData1_in,
    input  logic [DW-1:0]     rData2_in,
    output logic [DW-1:0]     rData1,
    output logic [DW-1:0]     rData2
);
    import regbank_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          any;
    logic          en;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          in_range;
    logic          legal;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reset also withdraws ready so a write granted during reset is never seen as accepted
    assign en = !stall && !reset;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (en),
        .grant  (req_ready),
        .winner (win),
        .any    (any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign in_range = 32'(sel_addr) < NREGS;
    assign legal    = in_range && (sel_addr != '0);

    // Issue stage: grant in cycle N appears on the bank port in N+1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            RegW     <= 1'b0;
            Rd       <= '0;
            wrData   <= '0;
            grant_id <= '0;
            err_addr <= 1'b0;
            drop_cnt <= '0;
        end else begin
            RegW <= any && legal;
            if (any) begin
                ptr      <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                Rd       <= sel_addr;
                wrData   <= sel_data;
                grant_id <= 2'(win);
                if (!legal)
                    drop_cnt <= sat_inc(drop_cnt);
                if (!in_range)
                    err_addr <= 1'b1;
            end
        end
    end

`ifdef REGW_BYPASS_EN
    assign rData1 = (RegW && (Rd == Rs) && (Rs != '0)) ? wrData : rData1_in;
    assign rData2 = (RegW && (Rd == Rt) && (Rt != '0)) ? wrData : rData2_in;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^{Rs, Rt};
    assign rData1 = rData1_in;
    assign rData2 = rData2_in;
`endif
endmodule

// File: tb/tb_regbank_wport_arb.sv
// Scoreboard bench for regbank_wport_arb: stimulus pushes expected issues, a negedge monitor pops them.
module tb_regbank_wport_arb;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef REGW_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              RegW;
    logic [AW-1:0]     Rd;
    logic [DW-1:0]     wrData;
    logic [1:0]        grant_id;
    logic              err_addr;
    logic [7:0]        drop_cnt;
    logic [AW-1:0]     Rs = '0;
    logic [AW-1:0]     Rt = '0;
    logic [DW-1:0]     rData1_in = '0;
    logic [DW-1:0]     rData2_in = '0;
    logic [DW-1:0]     rData1;
    logic [DW-1:0]     rData2;

    regbank_wport_arb dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .RegW(RegW), .Rd(Rd), .wrData(wrData),
        .grant_id(grant_id), .err_addr(err_addr), .drop_cnt(drop_cnt),
        .Rs(Rs), .Rt(Rt), .rData1_in(rData1_in), .rData2_in(rData2_in),
        .rData1(rData1), .rData2(rData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          regw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  id;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] bank [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle either an expected issue is due or the port must be idle
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("issue_regw", 32'(RegW), 32'(e.regw));
                if (e.regw) begin
                    chk("issue_rd", 32'(Rd), 32'(e.rd));
                    chk("issue_data", wrData, e.data);
                    chk("issue_id", 32'(grant_id), 32'(e.id));
                end
            end else begin
                chk("idle_regw", 32'(RegW), 32'd0);
            end
            if (RegW === 1'b1) bank[Rd] = wrData;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the following cycle
    task automatic issue(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                         input logic st, input logic [2:0] exp_rdy);
        exp_t e;
        logic [4:0] wa;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        stall     = st;
        @(negedge clk);
        chk("ready", 32'(req_ready), 32'(exp_rdy));
        for (int w = 0; w < NREQ; w++) begin
            if (exp_rdy[w]) begin
                wa     = a[w*AW +: AW];
                e.due  = cyc + 1;
                e.regw = (wa != 5'd0) && (wa < 5'd17);
                e.rd   = wa;
                e.data = d[w*DW +: DW];
                e.id   = 2'(w);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue(3'b000, '0, '0, 1'b0, 3'b000);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_regw", 32'(RegW), 32'd0);
        chk("rst_rd", 32'(Rd), 32'd0);
        chk("rst_wrdata", wrData, 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        // Single ALU write
        issue(3'b001, {5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'h55}, 1'b0, 3'b001);
        idle();
        do_reset();

        // All three valid: strict rotation 0,1,2,0,1,2
        for (int r = 0; r < 2; r++) begin
            issue(3'b111, {5'd9, 5'd8, 5'd7}, {32'h300 + r, 32'h200 + r, 32'h100 + r}, 1'b0, 3'b001);
            issue(3'b111, {5'd9, 5'd8, 5'd7}, {32'h300 + r, 32'h200 + r, 32'h100 + r}, 1'b0, 3'b010);
            issue(3'b111, {5'd9, 5'd8, 5'd7}, {32'h300 + r, 32'h200 + r, 32'h100 + r}, 1'b0, 3'b100);
        end
        idle();

        // Stall holds MEM off for three cycles
        for (int s = 0; s < 3; s++)
            issue(3'b010, {5'd0, 5'd11, 5'd0}, {32'd0, 32'hAB, 32'd0}, 1'b1, 3'b000);
        issue(3'b010, {5'd0, 5'd11, 5'd0}, {32'd0, 32'hAB, 32'd0}, 1'b0, 3'b010);
        idle();

        // SP to index 16 is legal; R0 and out-of-range are dropped
        issue(3'b100, {5'd16, 5'd0, 5'd0}, {32'd1019, 32'd0, 32'd0}, 1'b0, 3'b100);
        issue(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'hDEAD}, 1'b0, 3'b001);
        chk("drop_after_r0", 32'(drop_cnt), 32'd1);
        chk("err_after_r0", 32'(err_addr), 32'd0);
        issue(3'b010, {5'd0, 5'd20, 5'd0}, {32'd0, 32'hBEEF, 32'd0}, 1'b0, 3'b010);
        chk("drop_after_oor", 32'(drop_cnt), 32'd2);
        chk("err_after_oor", 32'(err_addr), 32'd1);
        idle();
        chk("err_sticky", 32'(err_addr), 32'd1);
        do_reset();

        // Same destination from ALU then MEM: later grant lands last
        issue(3'b011, {5'd0, 5'd5, 5'd5}, {32'd0, 32'h2, 32'h1}, 1'b0, 3'b001);
        issue(3'b010, {5'd0, 5'd5, 5'd5}, {32'd0, 32'h2, 32'h1}, 1'b0, 3'b010);
        idle();
        chk("bank_r5", bank[5], 32'h2);

        // Read bypass of the in-flight write
        issue(3'b001, {5'd0, 5'd0, 5'd4}, {32'd0, 32'd0, 32'd9}, 1'b0, 3'b001);
        req_valid = '0;
        Rs = 5'd4; rData1_in = 32'd7;
        Rt = 5'd4; rData2_in = 32'd8;
        #1;
        chk("byp_rdata1", rData1, BYP ? 32'd9 : 32'd7);
        chk("byp_rdata2", rData2, BYP ? 32'd9 : 32'd8);
        Rs = 5'd0;
        #1;
        chk("byp_rs0", rData1, 32'd7);
        idle();
        Rs = 5'd4;
        #1;
        chk("byp_no_regw", rData1, 32'd7);

        // Asynchronous reset while a write is on the port and another is being granted
        issue(3'b001, {5'd0, 5'd0, 5'd6}, {32'd0, 32'd0, 32'h66}, 1'b0, 3'b001);
        chk("pre_rst_regw", 32'(RegW), 32'd1);
        chk("pre_rst_ready", 32'(req_ready), 32'b001);
        reset = 1'b1;
        #1;
        chk("mid_rst_regw", 32'(RegW), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = '0;
        idle();
        idle();
        chk("post_rst_drop", 32'(drop_cnt), 32'd0);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
